// File: rtl/ksa_pkg.sv
// Shared types and timing constants for the RC4 key-scheduling stage.
package ksa_pkg;

  typedef enum logic [3:0] {
    IDLE, INIT, RD_I, LD_I, RD_J, LD_J, WR_I, WR_J, DONE
  } state_t;

  localparam int S_SIZE          = 256;
  localparam int CYCLES_PER_ITER = 6;
  localparam int KSA_LATENCY     = S_SIZE * CYCLES_PER_ITER;
  localparam int INIT_CYCLES     = S_SIZE;

endpackage

// File: rtl/key_byte_select.sv
// Picks key byte kidx out of the latched key; byte 0 is the most significant byte.
module key_byte_select #(
  parameter int KEY_BYTES = 3,
  parameter int KEY_WIDTH = 8*KEY_BYTES,
  parameter int KIW       = 2
) (
  input  logic [KEY_WIDTH-1:0] key,
  input  logic [KIW-1:0]       kidx,
  output logic [7:0]           key_byte
);

  logic [KEY_BYTES-1:0][7:0] bytes;

  genvar g;
  generate
    for (g = 0; g < KEY_BYTES; g++) begin : g_byte
      assign bytes[g] = key[KEY_WIDTH-1-8*g -: 8];
    end
  endgenerate

  // Compare-and-select keeps out-of-range kidx codes harmless for non-power-of-2 key sizes.
  always_comb begin
    key_byte = '0;
    for (int k = 0; k < KEY_BYTES; k++)
      if (kidx == KIW'(k)) key_byte = bytes[k];
  end

endmodule

// File: rtl/ksa_scheduler.sv
// RC4 key scheduler: permutes S in place, 6 cycles per i, all memory outputs registered.
// Optional KSA_INIT_EN adds an INIT pass writing S[a]=a before scheduling.
module ksa_scheduler
  import ksa_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int KEY_WIDTH = 8*KEY_BYTES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [KEY_WIDTH-1:0] secret_key,
  input  logic                 done_ack,
  output logic [7:0]           s_mem_addr,
  input  logic [7:0]           s_mem_data_read,
  output logic [7:0]           s_mem_data_write,
  output logic                 s_mem_wren,
  output logic                 busy,
  output logic                 done
);

  localparam int KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  state_t               state, state_n;
  logic [7:0]           i, i_n, j, j_n, si, si_n;
  logic [KIW-1:0]       kidx, kidx_n;
  logic [KEY_WIDTH-1:0] key_q, key_n;
  logic [7:0]           addr_n, wdata_n;
  logic                 wren_n, busy_n, done_n;
  logic [7:0]           kbyte, j_sum;

  key_byte_select #(
    .KEY_BYTES(KEY_BYTES),
    .KEY_WIDTH(KEY_WIDTH),
    .KIW      (KIW)
  ) u_ksel (
    .key     (key_q),
    .kidx    (kidx),
    .key_byte(kbyte)
  );

  assign j_sum = j + s_mem_data_read + kbyte;

  // Outputs are computed for the next state so the RAM sees them registered.
  always_comb begin
    state_n = state;
    i_n     = i;
    j_n     = j;
    si_n    = si;
    kidx_n  = kidx;
    key_n   = key_q;
    addr_n  = s_mem_addr;
    wdata_n = s_mem_data_write;
    wren_n  = 1'b0;
    busy_n  = busy;
    done_n  = done;
    case (state)
      IDLE: if (start) begin
        key_n  = secret_key;
        i_n    = '0;
        j_n    = '0;
        kidx_n = '0;
        busy_n = 1'b1;
        addr_n = '0;
`ifdef KSA_INIT_EN
        wdata_n = '0;
        wren_n  = 1'b1;
        state_n = INIT;
`else
        state_n = RD_I;
`endif
      end
`ifdef KSA_INIT_EN
      INIT: begin
        if (i == 8'hFF) begin
          i_n     = '0;
          addr_n  = '0;
          state_n = RD_I;
        end else begin
          i_n     = i + 8'd1;
          addr_n  = i + 8'd1;
          wdata_n = i + 8'd1;
          wren_n  = 1'b1;
        end
      end
`endif
      RD_I: state_n = LD_I;
      LD_I: begin
        si_n    = s_mem_data_read;
        j_n     = j_sum;
        addr_n  = j_sum;
        state_n = RD_J;
      end
      RD_J: state_n = LD_J;
      LD_J: begin
        addr_n  = i;
        wdata_n = s_mem_data_read;
        wren_n  = 1'b1;
        state_n = WR_I;
      end
      WR_I: begin
        addr_n  = j;
        wdata_n = si;
        wren_n  = 1'b1;
        state_n = WR_J;
      end
      WR_J: begin
        if (i == 8'hFF) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          i_n     = i + 8'd1;
          kidx_n  = (kidx == KIW'(KEY_BYTES-1)) ? '0 : kidx + 1'b1;
          addr_n  = i + 8'd1;
          state_n = RD_I;
        end
      end
      DONE: if (done_ack) begin
        done_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      i                <= '0;
      j                <= '0;
      si               <= '0;
      kidx             <= '0;
      key_q            <= '0;
      s_mem_addr       <= '0;
      s_mem_data_write <= '0;
      s_mem_wren       <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      state            <= state_n;
      i                <= i_n;
      j                <= j_n;
      si               <= si_n;
      kidx             <= kidx_n;
      key_q            <= key_n;
      s_mem_addr       <= addr_n;
      s_mem_data_write <= wdata_n;
      s_mem_wren       <= wren_n;
      busy             <= busy_n;
      done             <= done_n;
    end
  end

endmodule

// File: tb/tb_ksa_scheduler.sv
// Self-checking bench for ksa_scheduler: S RAM model, write log, software RC4 KSA reference.
module tb_ksa_scheduler;

  localparam int KB = 3;
  localparam int KW = 8*KB;
`ifdef KSA_INIT_EN
  localparam int LAT   = 1792;
  localparam int INITW = 256;
  localparam bit PRE_FF = 1'b1;
`else
  localparam int LAT   = 1536;
  localparam int INITW = 0;
  localparam bit PRE_FF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, done_ack;
  logic [KW-1:0] secret_key;
  logic [7:0]    s_mem_addr, s_mem_data_read, s_mem_data_write;
  logic          s_mem_wren, busy, done;

  ksa_scheduler #(.KEY_BYTES(KB), .KEY_WIDTH(KW)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .secret_key      (secret_key),
    .done_ack        (done_ack),
    .s_mem_addr      (s_mem_addr),
    .s_mem_data_read (s_mem_data_read),
    .s_mem_data_write(s_mem_data_write),
    .s_mem_wren      (s_mem_wren),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous S RAM; load_req refills it with identity or 0xFF.
  logic [7:0]  mem [256];
  logic        load_req = 1'b0;
  logic [15:0] wlog [$];
  always @(posedge clk) begin
    if (load_req) begin
      for (int a = 0; a < 256; a++) mem[a] <= PRE_FF ? 8'hFF : 8'(a);
    end else if (s_mem_wren) begin
      mem[s_mem_addr] <= s_mem_data_write;
    end
    s_mem_data_read <= mem[s_mem_addr];
    if (s_mem_wren) wlog.push_back({s_mem_addr, s_mem_data_write});
  end

  int passed = 0, total = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference RC4 KSA over an identity permutation.
  logic [7:0] ms [256];
  task automatic model(input logic [KW-1:0] key);
    logic [7:0] jj, t, kb;
    for (int a = 0; a < 256; a++) ms[a] = 8'(a);
    jj = 0;
    for (int n = 0; n < 256; n++) begin
      kb = 8'((key >> (8*(KB-1-(n % KB)))) & 'hFF);
      jj = jj + ms[n] + kb;
      t = ms[n]; ms[n] = ms[jj]; ms[jj] = t;
    end
  endtask

  task automatic cmp_s(input string nm);
    int bad = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== ms[a]) bad++;
    chk(nm, bad, 0);
  endtask

  task automatic run(input logic [KW-1:0] key, input int mid, input logic [KW-1:0] mkey,
                     output int base);
    int acc, got;
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
    base = wlog.size();
    start = 1'b1; secret_key = key;
    @(negedge clk); start = 1'b0; acc = cyc;
    chk("busy_after_start", busy, 1);
    got = 0;
    for (int n = 1; n <= 3000; n++) begin
      start    = (n == mid);
      done_ack = (n == mid + 3);
      if (n == mid) secret_key = mkey;
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    start = 1'b0; done_ack = 1'b0;
    chk("done_seen", got, 1);
    chk("done_latency", cyc - acc, LAT);
    chk("busy_at_done", busy, 0);
  endtask

  task automatic ack();
    @(negedge clk); done_ack = 1'b1;
    @(negedge clk); done_ack = 1'b0;
    chk("done_cleared", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  typedef struct {
    logic [KW-1:0] key;
    int            widx;
    logic [7:0]    addr;
    logic [7:0]    data;
  } vec_t;
  vec_t tbl [12];

  task automatic apply_tbl(input logic [KW-1:0] key, input int base);
    for (int t = 0; t < 12; t++)
      if (tbl[t].key == key)
        chk($sformatf("write%0d_key%0h", tbl[t].widx, key),
            wlog[base + INITW + tbl[t].widx], {tbl[t].addr, tbl[t].data});
  endtask

  initial begin
    int base, w0, bad;
    logic [KW-1:0] k1, k2;
    tbl[0]  = '{24'h000000, 0, 8'h00, 8'h00};
    tbl[1]  = '{24'h000000, 1, 8'h00, 8'h00};
    tbl[2]  = '{24'h000000, 2, 8'h01, 8'h01};
    tbl[3]  = '{24'h000000, 3, 8'h01, 8'h01};
    tbl[4]  = '{24'h000000, 4, 8'h02, 8'h03};
    tbl[5]  = '{24'h000000, 5, 8'h03, 8'h02};
    tbl[6]  = '{24'h000249, 0, 8'h00, 8'h00};
    tbl[7]  = '{24'h000249, 1, 8'h00, 8'h00};
    tbl[8]  = '{24'h000249, 2, 8'h01, 8'h03};
    tbl[9]  = '{24'h000249, 3, 8'h03, 8'h01};
    tbl[10] = '{24'h000249, 4, 8'h02, 8'h4E};
    tbl[11] = '{24'h000249, 5, 8'h4E, 8'h02};

    reset = 1'b1; start = 1'b0; done_ack = 1'b0; secret_key = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wren", s_mem_wren, 0);
    chk("rst_addr", s_mem_addr, 0);
    chk("rst_wdata", s_mem_data_write, 0);
    reset = 1'b0;

    // Key 0: early writes, full result, then a long un-acked DONE.
    run(24'h000000, 0, '0, base);
    apply_tbl(24'h000000, base);
`ifdef KSA_INIT_EN
    bad = 0;
    for (int a = 0; a < 256; a++) if (wlog[base + a] !== {8'(a), 8'(a)}) bad++;
    chk("init_writes", bad, 0);
`endif
    model(24'h000000);
    cmp_s("final_S_key0");
    w0 = wlog.size();
    for (int n = 0; n < 50; n++) begin
      start = (n == 10);
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_held", done, 1);
    chk("no_writes_in_done", wlog.size() - w0, 0);
    chk("start_in_done_ignored", busy, 0);
    ack();

    run(24'h000249, 0, '0, base);
    apply_tbl(24'h000249, base);
    model(24'h000249);
    cmp_s("final_S_key249");
    ack();

    // Restart attempt and key change mid-run.
    k1 = 24'($urandom); k2 = ~k1;
    run(k1, 100, k2, base);
    model(k1);
    cmp_s("mid_start_ignored");
    ack();

    // Reset during iteration 40.
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
    start = 1'b1; secret_key = 24'h123456;
    @(negedge clk); start = 1'b0;
    repeat (INITW + 40*6 + 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_wren", s_mem_wren, 0);
    reset = 1'b0;
    w0 = wlog.size();
    repeat (20) @(negedge clk);
    chk("midrst_no_writes", wlog.size() - w0, 0);
    k1 = 24'($urandom);
    run(k1, 0, '0, base);
    model(k1);
    cmp_s("after_reset_run");
    ack();

    for (int r = 0; r < 3; r++) begin
      k1 = 24'($urandom);
      run(k1, 0, '0, base);
      model(k1);
      cmp_s($sformatf("random_run%0d", r));
      ack();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ksa_scheduler.md
Name: ksa_scheduler

Overview:
RC4 key-scheduling stage, directly upstream of message_decryption. Permutes the 256-byte S working memory under a secret key: for i = 0..255, j = j + S[i] + key[i mod KEY_BYTES], then swap S[i] and S[j]. On `done`, S holds the permutation that message_decryption consumes. Shares the S-memory port with the decryption stage; the top-level mux grants the port to this block while `busy`=1.

Parameters:
- KEY_BYTES, 3, number of key bytes.
- KEY_WIDTH, 8*KEY_BYTES, width of `secret_key`.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to begin scheduling; sampled only in IDLE.
- secret_key  in  KEY_WIDTH  key; byte 0 = [KEY_WIDTH-1 -: 8] (MSB first); latched on start acceptance.
- done_ack  in  1  clears `done`.
- s_mem_addr  out  8  S address.
- s_mem_data_read  in  8  S read data; synchronous RAM, valid 1 cycle after address.
- s_mem_data_write  out  8  S write data.
- s_mem_wren  out  1  S write enable.
- busy  out  1  high from start acceptance until `done` asserts.
- done  out  1  scheduling complete; held until `done_ack`.

Behaviour:
- Reset (sync, active-high):
  - state=IDLE; i=0, j=0, key index=0.
  - All outputs 0.
  - Reset mid-operation aborts immediately: no further writes; S contents undefined.
- States: IDLE, RD_I, LD_I, RD_J, LD_J, WR_I, WR_J, DONE.
- IDLE:
  - start=1 -> latch key, i=0, j=0, kidx=0, busy=1, go to RD_I.
  - start=0 -> stay.
- RD_I: addr=i.
- LD_I:
  - capture si=s_mem_data_read.
  - j <= j + si + key[kidx], 8-bit wrap (mod 256).
- RD_J: addr=j.
- LD_J: capture sj.
- WR_I: addr=i, data=sj, wren=1.
- WR_J:
  - addr=j, data=si, wren=1.
  - If i==255 -> DONE.
  - Else i<=i+1; kidx<=(kidx==KEY_BYTES-1) ? 0 : kidx+1 (counter, no modulo); go to RD_I.
- Timing:
  - 6 cycles per iteration.
  - `done` rises exactly 1536 cycles after the start-accept edge (1792 with KSA_INIT_EN).
  - `busy` falls in the same cycle `done` rises.
- DONE:
  - done=1 until done_ack=1, then -> IDLE with done=0.
  - done_ack outside DONE has no effect.
  - start during DONE is ignored.
- i==j: both writes store the same value; must not corrupt S.
- start while busy: ignored. A key change mid-run has no effect.
- wren is 1 only in WR_I/WR_J (and INIT when enabled). addr/data are don't-care when wren=0, but must be glitch-free registered outputs.

Optional Feature:
- Macro: KSA_INIT_EN.
- Defined:
  - Extra INIT state between IDLE and RD_I.
  - Writes S[a]=a for a=0..255, one write per cycle (256 cycles), then enters RD_I.
  - `busy` covers INIT.
- Undefined:
  - No INIT state; S must already hold the identity permutation from the separate init stage.

Decomposition:
- Package ksa_pkg:
  - state enum.
  - S_SIZE=256.
  - CYCLES_PER_ITER=6.
  - KSA_LATENCY=1536.
  - INIT_CYCLES=256.
- Sub-module key_byte_select: combinational selection of key byte kidx from the latched key, so KEY_BYTES scales cleanly.

Test Plan:
1. Identity S, key 0x000000 -> first writes:
   - i=0: S[0]=0, S[0]=0.
   - i=1: S[1]=1, S[1]=1.
   - i=2: j=3, S[2]=3, S[3]=2.
   - Final S matches software RC4 KSA model; done at +1536 cycles.
2. Identity S, key 0x000249 -> i=0: j=0x00, no swap; i=1: j=0x03; i=2: j=0x4E. Full S matches model byte-for-byte.
3. Completion and handshake:
   - After completion, hold done_ack=0 for 50 cycles -> done stays 1, no writes.
   - Pulse done_ack -> done=0 next cycle, state IDLE; a new start then runs again.
4. Start pulse at cycle 100 of a run with a different key -> ignored; result equals single-run model with the original key.
5. Reset=1 at iteration 40 -> next cycle busy=0, done=0, wren=0. A following start with identity S reloaded gives a correct full result.
6. KSA_INIT_EN defined, S preloaded with 0xFF:
   - 256 init writes S[a]=a.
   - Final S equals test 1 result for key 0x000000.
   - done at +1792 cycles.
